// File: rtl/rv_decode_pkg.sv
// Shared encodings and entry layout for the rv32 registered decode stage.
package rv_decode_pkg;

    // Base opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // Operand and writeback selects
    localparam logic [1:0] SRC1_RS1  = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;
    localparam logic [1:0] SRC2_RS2  = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_FOUR = 2'd2;
    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic [1:0]  src1_sel;
        logic [1:0]  src2_sel;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic [31:0] imm;
        logic        branch;
        logic        jump;
        logic [31:0] branch_target;
        logic        illegal;
    } dec_ctl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        dec_ctl_t    ctl;
    } dec_entry_t;

    localparam int ENTRY_W = $bits(dec_entry_t);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side handshake and decoded-entry bus of the decode stage.
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src1_sel;
    logic [1:0]  alu_src2_sel;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  reg_src_sel;
    logic [31:0] imm;
    logic        branch;
    logic        jump;
    logic [31:0] branch_target;
    logic        illegal;

    // Decode stage view
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, rd_addr,
               alu_op, alu_src1_sel, alu_src2_sel, mem_read, mem_write,
               reg_write, reg_src_sel, imm, branch, jump, branch_target, illegal
    );

    // Fetch / execute environment view
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, rd_addr,
               alu_op, alu_src1_sel, alu_src2_sel, mem_read, mem_write,
               reg_write, reg_src_sel, imm, branch, jump, branch_target, illegal
    );
endinterface

// File: rtl/decode_comb.sv
// Pure combinational rv32 decode of one instruction word into control fields.
module decode_comb
    import rv_decode_pkg::*;
#(
    parameter bit RV32E      = 1'b0,
    parameter bit ILLEGAL_EN = 1'b1
) (
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output dec_ctl_t    ctl,
    output logic        rs1_used,
    output logic        rs2_used
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    logic rd_used;
    logic opc_ok;
    logic fn_ok;
    logic reg_ok;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Opcode decode, legality check and suppression of side effects on illegal entries
    always_comb begin
        ctl          = '0;
        ctl.rd       = rd;
        ctl.alu_op   = ALU_ADD;
        ctl.src1_sel = SRC1_RS1;
        ctl.src2_sel = SRC2_RS2;
        ctl.wb_sel   = WB_ALU;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        rd_used      = 1'b0;
        opc_ok       = 1'b1;
        fn_ok        = 1'b1;
        reg_ok       = 1'b1;

        case (opcode)
            OPC_LUI: begin
                ctl.src1_sel  = SRC1_ZERO;
                ctl.src2_sel  = SRC2_IMM;
                ctl.reg_write = 1'b1;
                ctl.imm       = imm_u;
                rd_used       = 1'b1;
            end
            OPC_AUIPC: begin
                ctl.src1_sel  = SRC1_PC;
                ctl.src2_sel  = SRC2_IMM;
                ctl.reg_write = 1'b1;
                ctl.imm       = imm_u;
                rd_used       = 1'b1;
            end
            OPC_JAL: begin
                ctl.src1_sel  = SRC1_PC;
                ctl.src2_sel  = SRC2_FOUR;
                ctl.jump      = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_PC4;
                ctl.imm       = imm_j;
                rd_used       = 1'b1;
            end
            OPC_JALR: begin
                ctl.src1_sel  = SRC1_PC;
                ctl.src2_sel  = SRC2_FOUR;
                ctl.jump      = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_PC4;
                ctl.imm       = imm_i;
                rs1_used      = 1'b1;
                rd_used       = 1'b1;
                fn_ok         = (funct3 == 3'd0);
            end
            OPC_BRANCH: begin
                ctl.alu_op = ALU_SUB;
                ctl.branch = 1'b1;
                ctl.imm    = imm_b;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
                fn_ok      = (funct3 != 3'd2) && (funct3 != 3'd3);
            end
            OPC_LOAD: begin
                ctl.src2_sel  = SRC2_IMM;
                ctl.mem_read  = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_MEM;
                ctl.imm       = imm_i;
                rs1_used      = 1'b1;
                rd_used       = 1'b1;
                fn_ok         = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            end
            OPC_STORE: begin
                ctl.src2_sel  = SRC2_IMM;
                ctl.mem_write = 1'b1;
                ctl.imm       = imm_s;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                fn_ok         = (funct3 <= 3'd2);
            end
            OPC_OP_IMM: begin
                ctl.src2_sel  = SRC2_IMM;
                ctl.alu_op    = alu_from_f3(funct3, (funct3 == 3'd5) && inst[30]);
                ctl.reg_write = 1'b1;
                ctl.imm       = imm_i;
                rs1_used      = 1'b1;
                rd_used       = 1'b1;
                if (funct3 == 3'd1)
                    fn_ok = (funct7 == 7'h00);
                else if (funct3 == 3'd5)
                    fn_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
            end
            OPC_OP: begin
                ctl.alu_op    = alu_from_f3(funct3, inst[30]);
                ctl.reg_write = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                rd_used       = 1'b1;
                fn_ok         = (funct7 == 7'h00) ||
                                ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            end
            default: opc_ok = 1'b0;
        endcase

        if (!ILLEGAL_EN)
            fn_ok = 1'b1;
        if (RV32E)
            reg_ok = !((rs1_used && rs1[4]) || (rs2_used && rs2[4]) || (rd_used && rd[4]));

        ctl.branch_target = pc + ctl.imm;

        if (!(opc_ok && fn_ok && reg_ok)) begin
            ctl.illegal   = 1'b1;
            ctl.mem_read  = 1'b0;
            ctl.mem_write = 1'b0;
            ctl.reg_write = 1'b0;
            ctl.branch    = 1'b0;
            ctl.jump      = 1'b0;
        end
        if (rd == 5'd0)
            ctl.reg_write = 1'b0;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, flow-controlled decode stage: decode at input, output register plus optional skid.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter bit RV32E      = 1'b0,
    parameter bit SKID_EN    = 1'b1,
    parameter bit ILLEGAL_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decode_stage_if.slave         bus,
    input  logic                  flush,
    input  logic                  ex_mem_read,
    input  logic [4:0]            ex_rd_addr,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [31:0]           rs1_data,
    input  logic [31:0]           rs2_data
);

    dec_ctl_t   ctl_p0;
    dec_entry_t ent_p0;
    dec_entry_t ent_p1;
    dec_entry_t skid_p1;
    logic       rs1_used_p0;
    logic       rs2_used_p0;

    buf_state_t state;
    buf_state_t state_nxt;
    logic       hazard;
    logic       room;
    logic       accept;
    logic       drain;
    logic       load_out;
    logic       load_skid;
    logic       skid_to_out;

    assign rs1_addr = bus.in_inst[19:15];
    assign rs2_addr = bus.in_inst[24:20];

    decode_comb #(
        .RV32E      (RV32E),
        .ILLEGAL_EN (ILLEGAL_EN)
    ) u_decode_comb (
        .inst     (bus.in_inst),
        .pc       (bus.in_pc),
        .ctl      (ctl_p0),
        .rs1_used (rs1_used_p0),
        .rs2_used (rs2_used_p0)
    );

    assign ent_p0.pc      = bus.in_pc;
    assign ent_p0.rs1_val = rs1_data;
    assign ent_p0.rs2_val = rs2_data;
    assign ent_p0.ctl     = ctl_p0;

    // Load-use stall: the load in EX writes a register this instruction reads.
    assign hazard = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((rs1_used_p0 && (ex_rd_addr == rs1_addr)) ||
                     (rs2_used_p0 && (ex_rd_addr == rs2_addr)));

    // Without skid the single register can only take a new entry as the old one leaves.
    assign room = SKID_EN ? (state != BUF_TWO) : ((state == BUF_EMPTY) || bus.out_ready);

    assign bus.in_ready  = room && !hazard && !flush;
    assign bus.out_valid = (state != BUF_EMPTY);
    assign accept        = bus.in_valid && bus.in_ready;
    assign drain         = bus.out_valid && bus.out_ready;

    // Buffer occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= BUF_EMPTY;
        else
            state <= state_nxt;
    end

    // Next occupancy and which buffer slot captures data this cycle
    always_comb begin
        state_nxt   = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        if (flush) begin
            state_nxt = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_nxt = BUF_ONE;
                        load_out  = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && drain) begin
                        load_out = 1'b1;
                    end else if (accept && SKID_EN) begin
                        state_nxt = BUF_TWO;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_nxt = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (drain) begin
                        state_nxt   = BUF_ONE;
                        skid_to_out = 1'b1;
                    end
                end
                default: state_nxt = BUF_EMPTY;
            endcase
        end
    end

    // Entry storage: output register is refilled from the input or promoted from skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_p1  <= '0;
            skid_p1 <= '0;
        end else begin
            if (load_out)
                ent_p1 <= ent_p0;
            else if (skid_to_out)
                ent_p1 <= skid_p1;
            if (load_skid)
                skid_p1 <= ent_p0;
        end
    end

    assign bus.out_pc        = ent_p1.pc;
    assign bus.out_rs1_val   = ent_p1.rs1_val;
    assign bus.out_rs2_val   = ent_p1.rs2_val;
    assign bus.rd_addr       = ent_p1.ctl.rd;
    assign bus.alu_op        = ent_p1.ctl.alu_op;
    assign bus.alu_src1_sel  = ent_p1.ctl.src1_sel;
    assign bus.alu_src2_sel  = ent_p1.ctl.src2_sel;
    assign bus.mem_read      = ent_p1.ctl.mem_read;
    assign bus.mem_write     = ent_p1.ctl.mem_write;
    assign bus.reg_write     = ent_p1.ctl.reg_write;
    assign bus.reg_src_sel   = ent_p1.ctl.wb_sel;
    assign bus.imm           = ent_p1.ctl.imm;
    assign bus.branch        = ent_p1.ctl.branch;
    assign bus.jump          = ent_p1.ctl.jump;
    assign bus.branch_target = ent_p1.ctl.branch_target;
    assign bus.illegal       = ent_p1.ctl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, hazard, skid, flush, illegal and reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd_addr;
    logic [4:0]  rs1_addr, rs2_addr, rs1_addr_e, rs2_addr_e;
    logic [31:0] rs1_data, rs2_data;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_BEQ  = 32'h00208C63;
    localparam logic [31:0] I_ADDI = 32'h00408193;
    localparam logic [31:0] I_X17  = 32'h002088B3;
    localparam logic [31:0] I_LUI1 = 32'h000080B7;
    localparam logic [31:0] I_BADF = 32'h802081B3;
    localparam logic [31:0] I_LW   = 32'h0080A283;

    always #5 clk = ~clk;

    decode_stage_if bus();
    decode_stage_if bus_e();

    decode_stage #(.RV32E(1'b0), .SKID_EN(1'b1), .ILLEGAL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data)
    );

    decode_stage #(.RV32E(1'b1), .SKID_EN(1'b1), .ILLEGAL_EN(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n), .bus(bus_e), .flush(flush),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .rs1_addr(rs1_addr_e), .rs2_addr(rs2_addr_e),
        .rs1_data(rs1_data), .rs2_data(rs2_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rd_addr = 5'd0;
        rs1_data = 32'd0; rs2_data = 32'd0;
        bus.in_valid = 1'b0; bus.in_inst = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b1;
        bus_e.in_valid = 1'b0; bus_e.in_inst = 32'd0; bus_e.in_pc = 32'd0; bus_e.out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++;
        if ({bus.out_pc, bus.rd_addr, bus.alu_op, bus.reg_write, bus.imm, bus.branch_target, bus.illegal} !== '0) begin
            failures++; $display("FAIL reset_fields got pc=%h rd=%0d imm=%h tgt=%h exp all 0", bus.out_pc, bus.rd_addr, bus.imm, bus.branch_target);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        checks++;
        if (bus_e.out_valid !== 1'b0) begin failures++; $display("FAIL reset_e_out_valid got=%0b exp=0", bus_e.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        bus.in_valid = 1'b1; bus.in_inst = I_ADD; bus.in_pc = 32'h1000;
        rs1_data = 32'd5; rs2_data = 32'd7; bus.out_ready = 1'b1;
        #1;
        checks++;
        if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin failures++; $display("FAIL add_rs_addr got=%0d,%0d exp=1,2", rs1_addr, rs2_addr); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready got=%0b exp=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%0b exp=1", bus.out_valid); end
        checks++;
        if ({bus.rd_addr, bus.alu_op, bus.reg_write, bus.alu_src2_sel, bus.reg_src_sel} !== {5'd3, 4'd0, 1'b1, 2'd0, 2'd0}) begin
            failures++; $display("FAIL add_ctl got rd=%0d op=%0d rw=%0b s2=%0d wb=%0d exp rd=3 op=0 rw=1 s2=0 wb=0",
                bus.rd_addr, bus.alu_op, bus.reg_write, bus.alu_src2_sel, bus.reg_src_sel);
        end
        checks++;
        if ({bus.out_pc, bus.out_rs1_val, bus.out_rs2_val} !== {32'h1000, 32'd5, 32'd7}) begin
            failures++; $display("FAIL add_data got pc=%h rs1=%0d rs2=%0d exp pc=1000 rs1=5 rs2=7", bus.out_pc, bus.out_rs1_val, bus.out_rs2_val);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_drained got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_branch();
        bus.in_valid = 1'b1; bus.in_inst = I_BEQ; bus.in_pc = 32'h1000;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.branch, bus.jump, bus.reg_write, bus.alu_op} !== {1'b1, 1'b0, 1'b0, 4'd1}) begin
            failures++; $display("FAIL beq_ctl got br=%0b j=%0b rw=%0b op=%0d exp br=1 j=0 rw=0 op=1", bus.branch, bus.jump, bus.reg_write, bus.alu_op);
        end
        checks++;
        if ({bus.imm, bus.branch_target} !== {32'h18, 32'h1018}) begin
            failures++; $display("FAIL beq_imm got imm=%h tgt=%h exp imm=18 tgt=1018", bus.imm, bus.branch_target);
        end
        tick();
    endtask

    task automatic test_hazard();
        ex_mem_read = 1'b1; ex_rd_addr = 5'd1;
        bus.in_valid = 1'b1; bus.in_inst = I_ADD; bus.in_pc = 32'h1100;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hazard_in_ready got=%0b exp=0", bus.in_ready); end
        tick(); tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hazard_no_entry got=%0b exp=0", bus.out_valid); end
        bus.in_valid = 1'b0; bus.in_inst = I_LUI1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL hazard_lui_unused_rs got=%0b exp=1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_inst = I_ADD; ex_rd_addr = 5'd0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL hazard_x0_in_ready got=%0b exp=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0; ex_mem_read = 1'b0;
        checks++;
        if ({bus.out_valid, bus.rd_addr, bus.out_pc} !== {1'b1, 5'd3, 32'h1100}) begin
            failures++; $display("FAIL hazard_release got v=%0b rd=%0d pc=%h exp v=1 rd=3 pc=1100", bus.out_valid, bus.rd_addr, bus.out_pc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = I_ADDI; bus.in_pc = 32'h2000;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%0b exp=1", bus.in_ready); end
        tick();
        bus.in_pc = 32'h2004;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%0b exp=1", bus.in_ready); end
        tick();
        bus.in_pc = 32'h2008;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready2_full got=%0b exp=0", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h2000}) begin
            failures++; $display("FAIL b2b_hold got v=%0b pc=%h exp v=1 pc=2000", bus.out_valid, bus.out_pc);
        end
        checks++;
        if ({bus.imm, bus.alu_src2_sel, bus.rd_addr, bus.alu_op} !== {32'd4, 2'd1, 5'd3, 4'd0}) begin
            failures++; $display("FAIL addi_ctl got imm=%h s2=%0d rd=%0d op=%0d exp imm=4 s2=1 rd=3 op=0", bus.imm, bus.alu_src2_sel, bus.rd_addr, bus.alu_op);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h2004}) begin
            failures++; $display("FAIL b2b_second got v=%0b pc=%h exp v=1 pc=2004", bus.out_valid, bus.out_pc);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = I_ADD; bus.in_pc = 32'h3000;
        tick();
        bus.in_pc = 32'h3004;
        tick();
        flush = 1'b1; bus.in_pc = 32'h3008;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0b exp=0", bus.in_ready); end
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== {1'b0, 1'b1}) begin
            failures++; $display("FAIL flush_empty got v=%0b rdy=%0b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_pc = 32'h3010; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h3010}) begin
            failures++; $display("FAIL flush_next_entry got v=%0b pc=%h exp v=1 pc=3010", bus.out_valid, bus.out_pc);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_drain got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        bus.in_valid = 1'b1; bus.in_inst = I_X17; bus.in_pc = 32'h5000;
        bus_e.in_valid = 1'b1; bus_e.in_inst = I_X17; bus_e.in_pc = 32'h5000;
        tick();
        bus_e.in_valid = 1'b0;
        checks++;
        if ({bus_e.out_valid, bus_e.illegal, bus_e.reg_write} !== {1'b1, 1'b1, 1'b0}) begin
            failures++; $display("FAIL rv32e_x17 got v=%0b ill=%0b rw=%0b exp v=1 ill=1 rw=0", bus_e.out_valid, bus_e.illegal, bus_e.reg_write);
        end
        checks++;
        if ({bus.illegal, bus.reg_write, bus.rd_addr} !== {1'b0, 1'b1, 5'd17}) begin
            failures++; $display("FAIL rv32i_x17 got ill=%0b rw=%0b rd=%0d exp ill=0 rw=1 rd=17", bus.illegal, bus.reg_write, bus.rd_addr);
        end
        bus.in_inst = I_BADF;
        tick();
        checks++;
        if ({bus.out_valid, bus.illegal, bus.reg_write} !== {1'b1, 1'b1, 1'b0}) begin
            failures++; $display("FAIL bad_funct7 got v=%0b ill=%0b rw=%0b exp v=1 ill=1 rw=0", bus.out_valid, bus.illegal, bus.reg_write);
        end
        bus.in_inst = I_LW;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.mem_read, bus.mem_write, bus.reg_src_sel, bus.imm, bus.rd_addr, bus.illegal} !== {1'b1, 1'b0, 2'd1, 32'd8, 5'd5, 1'b0}) begin
            failures++; $display("FAIL lw_ctl got mr=%0b mw=%0b wb=%0d imm=%h rd=%0d ill=%0b exp mr=1 mw=0 wb=1 imm=8 rd=5 ill=0",
                bus.mem_read, bus.mem_write, bus.reg_src_sel, bus.imm, bus.rd_addr, bus.illegal);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = I_ADD; bus.in_pc = 32'h4000;
        tick();
        bus.in_pc = 32'h4004;
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.rd_addr, bus.reg_write} !== {1'b0, 32'h0, 5'd0, 1'b0}) begin
            failures++; $display("FAIL async_reset got v=%0b pc=%h rd=%0d rw=%0b exp all 0", bus.out_valid, bus.out_pc, bus.rd_addr, bus.reg_write);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%0b exp=1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL async_reset_after got=%0b exp=0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_hazard();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, flow-controlled successor to the combinational `decode` block for the rv32 core.
- Accepts fetched instructions over a valid/ready handshake and decodes them using the same control-field set as `decode`.
- Detects load-use hazards against EX, flags illegal encodings, supports flush, and buffers up to two decoded entries (output register plus skid) so the pipeline keeps full throughput under back-pressure.
- Sits between fetch and execute.

Parameters:
- RV32E, 0: 1 restricts the register file to x0-x15; any rs1/rs2/rd >= 16 is illegal.
- SKID_EN, 1: 1 adds a skid entry for 2-deep buffering; 0 gives a single output register.
- ILLEGAL_EN, 1: 1 checks funct3/funct7 validity; 0 checks opcode only.

Ports:
- clk in 1: clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- in_valid in 1: fetch presents an instruction.
- in_ready out 1: stage accepts the instruction this cycle.
- in_inst in 32: instruction word.
- in_pc in 32: instruction address.
- flush in 1: discard all buffered entries; takes priority over everything else.
- ex_mem_read in 1: the instruction in EX is a load.
- ex_rd_addr in 5: destination register of the instruction in EX.
- rs1_addr out 5: combinational from in_inst[19:15], to the register file.
- rs2_addr out 5: combinational from in_inst[24:20], to the register file.
- rs1_data in 32: register file read data, same cycle.
- rs2_data in 32: register file read data, same cycle.
- out_valid out 1: decoded entry available.
- out_ready in 1: EX accepts the entry.
- out_pc out 32: pc of the entry.
- out_rs1_val out 32: captured rs1 value.
- out_rs2_val out 32: captured rs2 value.
- rd_addr out 5: destination register.
- alu_op out 4: ALU operation.
- alu_src1_sel out 2: ALU operand 1 select.
- alu_src2_sel out 2: ALU operand 2 select.
- mem_read out 1: load.
- mem_write out 1: store.
- reg_write out 1: register writeback.
- reg_src_sel out 2: writeback source select.
- imm out 32: sign-extended immediate.
- branch out 1: conditional branch.
- jump out 1: JAL or JALR.
- branch_target out 32: in_pc + imm.
- illegal out 1: illegal instruction flag.

Behaviour:
- Reset: every output register is 0 and the buffer state is EMPTY. in_ready is 1 after reset, subject to the hazard term.
- Buffer states are EMPTY, ONE and TWO; TWO exists only when SKID_EN=1.
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = (state != TWO) & ~hazard & ~flush when SKID_EN=1.
- in_ready = (state == EMPTY | out_ready) & ~hazard & ~flush when SKID_EN=0.
- State transitions:
  - EMPTY --accept--> ONE.
  - ONE --accept & ~drain--> TWO.
  - ONE --drain & ~accept--> EMPTY.
  - ONE --accept & drain--> ONE; the new entry loads the output register.
  - TWO --drain--> ONE; skid moves to the output register in the same cycle.
- Latency: 1 cycle from accept to out_valid. Entries leave in strict FIFO order.
- out_valid = (state != EMPTY). Output fields are stable while out_valid & ~out_ready.
- Hazard:
  - hazard = ex_mem_read & ex_rd_addr != 0 & (ex_rd_addr == rs1 used | ex_rd_addr == rs2 used).
  - rs1 is used by R, I, S, B and JALR; rs2 is used by R, S and B.
  - While hazard is high, in_ready = 0 and no bubble entry is created.
- Flush: the next state is EMPTY, out_valid = 0 the following cycle, and an input presented in the flush cycle is dropped.
- Decode encodings:
  - alu_op: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10. Branches use SUB.
  - alu_src1_sel: 0 = rs1, 1 = pc, 2 = zero.
  - alu_src2_sel: 0 = rs2, 1 = imm, 2 = constant 4.
  - reg_src_sel: 0 = alu, 1 = mem, 2 = pc+4.
- Per-opcode decode:
  - LUI: src1 = zero, src2 = imm, op = ADD.
  - AUIPC: src1 = pc, src2 = imm, op = ADD.
  - JAL / JALR: jump = 1, reg_write = 1, reg_src_sel = 2.
  - Stores and branches: reg_write = 0.
  - rd = 0: reg_write is forced to 0.
- Immediates are built per I/S/B/U/J type and sign-extended to 32 bits. branch_target wraps modulo 2^32.
- Illegal entries: illegal = 1 and mem_read, mem_write, reg_write, branch and jump are all forced to 0. The entry still flows through the buffer.

Decomposition:
- Package `rv_decode_pkg`:
  - Opcode constants.
  - ALU_* codes.
  - SRC1_*, SRC2_* and WB_* select codes.
  - Decoded-entry struct width constant.
- Sub-module `decode_comb`: pure combinational decode of inst/pc to control fields plus illegal. Used once, at the input side.
- The entry buffer and FSM stay in `decode_stage`.

Test Plan:
- ADD 0x002081B3, pc 0x1000, EX idle, out_ready = 1: out_valid next cycle with rd = 3, alu_op = 0, reg_write = 1, out_pc = 0x1000.
- BEQ 0x00208C63, pc 0x1000: branch = 1, imm = 0x18, branch_target = 0x1018, reg_write = 0, alu_op = 1.
- ex_mem_read = 1, ex_rd_addr = 1, in_inst = ADD 0x002081B3: in_ready = 0, and no new entry is accepted while hazard holds. With ex_rd_addr = 0, in_ready = 1.
- out_ready = 0 with three back-to-back ADDI 0x00408193 offered (SKID_EN = 1): two accepted, in_ready = 0 on the third. Releasing out_ready drains entries in order, one per cycle.
- flush asserted with state TWO: out_valid = 0 the next cycle, in_ready = 1 again, and no entry is lost to misordering.
- RV32E = 1, add x17,x1,x2 (0x002088B3): illegal = 1 and reg_write = 0.
- Async reset mid-stream, state TWO: all outputs 0 immediately, state EMPTY.
